core_reset_sequencer: RTL
=========================

// Module: core_reset_sequencer
// PURPOSE
//  Sits between the Zynq PS reset/config outputs and pardcore, on the uncore clock. Turns raw per-core
//  reset requests into a safe sequence: quiesce the M_AXI_MEM address channels, drain outstanding
//  transactions, hold the cores in reset, then release them one at a time. Also latches nohype_settings
//  while the cores are held, so pardcore never sees a settings change while running.
// PARAMETERS
//  NCORE        2    cores; width of reset request/out vectors
//  NSET         3    nohype settings width (mem_part_en, reset_to_hang_en, distinct_hart_dsid_en)
//  HOLD_CYCLES  16   cycles all requested cores stay in reset after drain (>=1)
//  STAGGER      4    cycles between consecutive per-core releases (>=1)
//  OUTST_W      6    outstanding-transaction counter width per direction
// PORTS
//  uncoreclk     in   1        clock
//  uncorerstn    in   1        synchronous active-low reset
//  req_rstn      in   NCORE    per-core reset request from PS, active-low, uncoreclk-synchronous
//  settings_in   in   NSET     nohype settings from PS
//  settings_out  out  NSET     latched settings to pardcore
//  core_rstn     out  NCORE    per-core reset to pardcore, active-low
//  s_awvalid/s_awready, s_arvalid/s_arready  in/out 1  address handshake, pardcore side
//  m_awvalid/m_awready, m_arvalid/m_arready  out/in 1  address handshake, memory side
//  bvalid, bready, rvalid, rready, rlast     in   1    response snoop (not modified)
//  busy          out  1        high in any state other than RUN
// BEHAVIOUR
//  Reset (uncorerstn=0 at edge): state=HOLD, hold_cnt=0, core_rstn=0, settings_out=0, counters=0,
//   busy=1, ack_mask=all ones. Gating active (no new address beats), counters stay 0.
//  Outstanding counters: wr_cnt +1 on m_awvalid&m_awready, -1 on bvalid&bready; rd_cnt +1 on
//   m_arvalid&m_arready, -1 on rvalid&rready&rlast; same cycle inc+dec = no change; saturate at max
//   (never wrap; inc at max is held). Dec at 0 ignored.
//  Gating: aw_pend set when s_awvalid&~s_awready, cleared on handshake (same for ar). While gate=1,
//   m_awvalid=s_awvalid&aw_pend, s_awready=m_awready&aw_pend; an address already presented always
//   completes (AXI valid-stability). gate=0 -> pure pass-through (combinational, zero latency).
//  FSM:
//   RUN:     gate=0. If any req_rstn bit 0 -> latch rst_mask=~req_rstn, go BLOCK.
//   BLOCK:   gate=1. When aw_pend=0 and ar_pend=0 -> DRAIN.
//   DRAIN:   gate=1. When wr_cnt=0 and rd_cnt=0 -> HOLD; drive core_rstn[i]=0 for rst_mask[i].
//   HOLD:    gate=1; rst_mask cores held; counts HOLD_CYCLES. settings_out<=settings_in on the entry
//            cycle, frozen otherwise. At count end, if req_rstn still has any 0 bit, stay in HOLD
//            (rst_mask|=~req_rstn, counter restarts). Else idx=0 -> RELEASE.
//   RELEASE: gate=1. Every STAGGER cycles release lowest-index still-held core (core_rstn[i]=1).
//            After last release -> RUN. A new 0 on req_rstn in RELEASE -> back to HOLD, re-asserting
//            all masked cores incl. already released ones (they were idle; bus still gated).
//  Cores not in rst_mask keep core_rstn=1 throughout but see gated bus until RUN.
//  Out of reset: all cores in rst_mask (all ones), so first RUN follows full HOLD+RELEASE.
//  Latency: RUN->BLOCK 1 cycle after req_rstn falls; first core_rstn low earliest 3 cycles after.
//  Reset mid-operation: any state -> HOLD with all cores reset; counters cleared (pardcore uncore is
//   reset together, so no stale responses are expected).
//  busy=0 only in RUN. All outputs registered except gated handshake signals.
// TESTING
//  1 Power-on: uncorerstn low 5 cyc, req_rstn=2'b11, settings_in=3'b101 -> core_rstn=00 for 16 cyc,
//    core0 released cyc 17, core1 cyc 21, settings_out=101, busy falls with last release.
//  2 Drain: 3 AW + 2 AR accepted, no B/R; req_rstn[0]=0 -> state DRAIN, core_rstn stays 11;
//    return 3 B and 2 R(rlast) -> core_rstn[0]=0 next cycle, core1 stays 1.
//  3 Pending addr: s_awvalid=1, m_awready=0 when req falls -> m_awvalid held 1; accept at
//    m_awready=1, wr_cnt=1; a new s_arvalid after gate stays blocked (m_arvalid=0, s_arready=0).
//  4 Settings: settings_in toggles 000->111 during RUN -> settings_out unchanged until next HOLD entry.
//  5 Re-request in RELEASE: core0 released, req_rstn[1]=0 again -> both core_rstn=0, full HOLD repeats.
//  6 Simultaneous inc/dec with wr_cnt=1: AW and B handshake same cycle -> wr_cnt stays 1; saturation at 63.

Source files
------------

// File: rtl/core_reset_sequencer_if.sv
// Address-channel handshake and response-snoop bundle around the core
// reset sequencer.
//   s_*  : pardcore-side address handshake (valid in, ready out of the sequencer)
//   m_*  : memory-side address handshake (valid out of the sequencer, ready in)
//   b*/r*: write/read response handshakes, observed only, never modified
// The slave modport is the sequencer's view; master is the surrounding fabric's.
interface core_reset_sequencer_if;
   logic s_awvalid;
   logic s_awready;
   logic s_arvalid;
   logic s_arready;
   logic m_awvalid;
   logic m_awready;
   logic m_arvalid;
   logic m_arready;
   logic bvalid;
   logic bready;
   logic rvalid;
   logic rready;
   logic rlast;

   modport slave (
      input  s_awvalid, s_arvalid, m_awready, m_arready,
      input  bvalid, bready, rvalid, rready, rlast,
      output s_awready, s_arready, m_awvalid, m_arvalid
   );

   modport master (
      output s_awvalid, s_arvalid, m_awready, m_arready,
      output bvalid, bready, rvalid, rready, rlast,
      input  s_awready, s_arready, m_awvalid, m_arvalid
   );
endinterface

// File: rtl/core_reset_sequencer.sv
// Core reset sequencer between the PS reset/config outputs and pardcore.
// Turns raw per-core reset requests into a safe sequence: gate new address
// beats, drain outstanding transactions, hold the requested cores in reset,
// then release them one at a time. nohype settings are only sampled on HOLD
// entry, so a running core never sees them change.
// Ports:
//   uncoreclk     clock
//   uncorerstn    synchronous active-low reset
//   req_rstn      per-core reset request (active-low, uncoreclk domain)
//   settings_in   nohype settings from the PS
//   settings_out  settings latched for pardcore
//   core_rstn     per-core reset to pardcore (active-low)
//   busy          high whenever the sequencer is not in RUN
//   bus           address handshakes (gated) and response snoop
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | bus passes straight through, watching req_rstn
// BLOCK   | new address beats blocked, waiting for presented ones to finish
// DRAIN   | waiting for outstanding write/read counts to reach zero
// HOLD    | masked cores held in reset for HOLD_CYCLES, settings latched
// RELEASE | masked cores released lowest-first, STAGGER cycles apart
module core_reset_sequencer #(
   parameter int NCORE       = 2,
   parameter int NSET        = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGGER     = 4,
   parameter int OUTST_W     = 6
) (
   input  logic                 uncoreclk,
   input  logic                 uncorerstn,
   input  logic [NCORE-1:0]     req_rstn,
   input  logic [NSET-1:0]      settings_in,
   output logic [NSET-1:0]      settings_out,
   output logic [NCORE-1:0]     core_rstn,
   output logic                 busy,
   core_reset_sequencer_if.slave bus
);

   localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
   localparam int SCNT_W = $clog2(STAGGER + 1);
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
   localparam logic [SCNT_W-1:0] STAG_LAST = SCNT_W'(STAGGER - 1);

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_BLOCK   = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [HCNT_W-1:0]    hold_cnt, hold_cnt_nxt;
   logic [SCNT_W-1:0]    stag_cnt, stag_cnt_nxt;
   logic [NCORE-1:0]     rst_mask, rst_mask_nxt;
   logic [NCORE-1:0]     core_rstn_nxt;
   logic                 hold_first, hold_first_nxt;
   logic [NSET-1:0]      settings_nxt;

   logic                 aw_pend, ar_pend;
   logic [OUTST_W-1:0]   wr_cnt, rd_cnt;
   logic                 gate;

   logic [NCORE-1:0]     req_mask;
   logic                 req_any;
   logic [NCORE-1:0]     held;
   logic [NCORE-1:0]     rel_low;
   logic                 last_rel;

   logic                 wr_inc, wr_dec, rd_inc, rd_dec;

   assign gate     = (state != ST_RUN);
   assign req_mask = ~req_rstn;
   assign req_any  = |req_mask;

   // Cores still waiting for release; rel_low isolates the lowest of them.
   assign held     = rst_mask & ~core_rstn;
   assign rel_low  = held & (~held + NCORE'(1));
   assign last_rel = ((held & ~rel_low) == '0);

   // While gated, only an address that was already presented before the
   // gate closed may complete; anything new sees valid and ready both low.
   always_comb begin
      bus.m_awvalid = bus.s_awvalid;
      bus.s_awready = bus.m_awready;
      bus.m_arvalid = bus.s_arvalid;
      bus.s_arready = bus.m_arready;
      if (gate) begin
         bus.m_awvalid = bus.s_awvalid & aw_pend;
         bus.s_awready = bus.m_awready & aw_pend;
         bus.m_arvalid = bus.s_arvalid & ar_pend;
         bus.s_arready = bus.m_arready & ar_pend;
      end
   end

   assign wr_inc = bus.m_awvalid & bus.m_awready;
   assign wr_dec = bus.bvalid & bus.bready;
   assign rd_inc = bus.m_arvalid & bus.m_arready;
   assign rd_dec = bus.rvalid & bus.rready & bus.rlast;

   // Saturating up/down count: held at max on overflow, decrement at zero ignored.
   function automatic logic [OUTST_W-1:0] cnt_step(input logic [OUTST_W-1:0] cnt,
                                                   input logic inc, input logic dec);
      cnt_step = cnt;
      if (inc && !dec && (cnt != '1))
         cnt_step = cnt + OUTST_W'(1);
      else if (dec && !inc && (cnt != '0))
         cnt_step = cnt - OUTST_W'(1);
   endfunction

   // A pending address is one that was presented but not accepted while the
   // bus was open; it stays pending until it handshakes or valid drops.
   function automatic logic pend_step(input logic pend, input logic valid,
                                      input logic ready, input logic gated);
      if (!valid || ready)
         pend_step = 1'b0;
      else if (!gated)
         pend_step = 1'b1;
      else
         pend_step = pend;
   endfunction

   always_comb begin
      state_nxt      = state;
      hold_cnt_nxt   = hold_cnt;
      stag_cnt_nxt   = stag_cnt;
      rst_mask_nxt   = rst_mask;
      core_rstn_nxt  = core_rstn;
      hold_first_nxt = hold_first;
      settings_nxt   = settings_out;

      case (state)
         ST_RUN: begin
            if (req_any) begin
               rst_mask_nxt = req_mask;
               state_nxt    = ST_BLOCK;
            end
         end

         ST_BLOCK: begin
            if (!aw_pend && !ar_pend)
               state_nxt = ST_DRAIN;
         end

         ST_DRAIN: begin
            if ((wr_cnt == '0) && (rd_cnt == '0)) begin
               core_rstn_nxt  = ~rst_mask;
               hold_cnt_nxt   = '0;
               hold_first_nxt = 1'b1;
               state_nxt      = ST_HOLD;
            end
         end

         ST_HOLD: begin
            hold_first_nxt = 1'b0;
            if (hold_first)
               settings_nxt = settings_in;
            if (hold_cnt == HOLD_LAST) begin
               if (req_any) begin
                  rst_mask_nxt  = rst_mask | req_mask;
                  core_rstn_nxt = ~(rst_mask | req_mask);
                  hold_cnt_nxt  = '0;
               end else begin
                  // First release happens on the exit edge; a single masked
                  // core therefore goes straight back to RUN.
                  core_rstn_nxt = core_rstn | rel_low;
                  stag_cnt_nxt  = STAG_LAST;
                  state_nxt     = last_rel ? ST_RUN : ST_RELEASE;
               end
            end else begin
               hold_cnt_nxt = hold_cnt + HCNT_W'(1);
            end
         end

         ST_RELEASE: begin
            if (req_any) begin
               // Already-released masked cores are idle behind the gate, so
               // pulling them back into reset is safe.
               rst_mask_nxt   = rst_mask | req_mask;
               core_rstn_nxt  = ~(rst_mask | req_mask);
               hold_cnt_nxt   = '0;
               hold_first_nxt = 1'b1;
               state_nxt      = ST_HOLD;
            end else if (stag_cnt == '0) begin
               core_rstn_nxt = core_rstn | rel_low;
               stag_cnt_nxt  = STAG_LAST;
               if (last_rel)
                  state_nxt = ST_RUN;
            end else begin
               stag_cnt_nxt = stag_cnt - SCNT_W'(1);
            end
         end

         default: begin
            state_nxt = ST_HOLD;
         end
      endcase
   end

   always_ff @(posedge uncoreclk) begin
      if (!uncorerstn) begin
         state        <= ST_HOLD;
         hold_cnt     <= '0;
         stag_cnt     <= '0;
         rst_mask     <= '1;
         core_rstn    <= '0;
         hold_first   <= 1'b1;
         settings_out <= '0;
         busy         <= 1'b1;
         aw_pend      <= 1'b0;
         ar_pend      <= 1'b0;
         wr_cnt       <= '0;
         rd_cnt       <= '0;
      end else begin
         state        <= state_nxt;
         hold_cnt     <= hold_cnt_nxt;
         stag_cnt     <= stag_cnt_nxt;
         rst_mask     <= rst_mask_nxt;
         core_rstn    <= core_rstn_nxt;
         hold_first   <= hold_first_nxt;
         settings_out <= settings_nxt;
         busy         <= (state_nxt != ST_RUN);
         aw_pend      <= pend_step(aw_pend, bus.s_awvalid, bus.s_awready, gate);
         ar_pend      <= pend_step(ar_pend, bus.s_arvalid, bus.s_arready, gate);
         wr_cnt       <= cnt_step(wr_cnt, wr_inc, wr_dec);
         rd_cnt       <= cnt_step(rd_cnt, rd_inc, rd_dec);
      end
   end

endmodule
